// File: rtl/dps_port_responder.sv
// Responder for the MMCM dynamic-phase-shift port: emulated lock, fixed-latency psdone, step count.
// Build option DPS_RESP_PHASE_WRAP_EN: phase count wraps modulo STEPS_PER_PERIOD instead of saturating.
//
// state      | meaning
// S_LOCKWAIT | counting out LOCK_DELAY after reset, requests rejected
// S_IDLE     | locked, ready to accept a step
// S_BUSY     | step in flight, latency counter running
module dps_port_responder #(
  parameter int PSDONE_LATENCY   = 12,
  parameter int LOCK_DELAY       = 16,
`ifdef DPS_RESP_PHASE_WRAP_EN
  parameter int STEPS_PER_PERIOD = 448,
`endif
  parameter int PHASE_W          = 16
) (
  input  logic               psclk_i,
  input  logic               rstn_i,
  input  logic               psen_i,
  input  logic               psincdec_i,
  output logic               locked_o,
  output logic               psdone_o,
  output logic               busy_o,
  output logic [PHASE_W-1:0] phase_steps_o,
  output logic               err_busy_o,
  output logic               err_unlocked_o,
  output logic               sat_o
);

  typedef enum logic [1:0] {S_LOCKWAIT, S_IDLE, S_BUSY} state_t;

  localparam logic [7:0]  LAT_LOAD = 8'(PSDONE_LATENCY - 1);
  localparam logic [15:0] LOCK_TC  = 16'(LOCK_DELAY - 1);

  state_t               state_q, state_d;
  logic [15:0]          lock_cnt_q, lock_cnt_d;
  logic [7:0]           lat_cnt_q, lat_cnt_d;
  logic                 dir_q, dir_d;
  logic                 locked_q, locked_d;
  logic                 psdone_q, psdone_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 err_busy_q, err_busy_d;
  logic                 err_unl_q, err_unl_d;
  logic                 sat_q, sat_d;
  logic [PHASE_W-1:0]   phase_nxt;
  logic                 sat_hit;

  always_ff @(posedge psclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_LOCKWAIT;
      lock_cnt_q <= '0;
      lat_cnt_q  <= '0;
      dir_q      <= 1'b0;
      locked_q   <= 1'b0;
      psdone_q   <= 1'b0;
      phase_q    <= '0;
      err_busy_q <= 1'b0;
      err_unl_q  <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      dir_q      <= dir_d;
      locked_q   <= locked_d;
      psdone_q   <= psdone_d;
      phase_q    <= phase_d;
      err_busy_q <= err_busy_d;
      err_unl_q  <= err_unl_d;
      sat_q      <= sat_d;
    end
  end

`ifdef DPS_RESP_PHASE_WRAP_EN
  localparam logic [PHASE_W-1:0] WRAP_TOP = PHASE_W'(STEPS_PER_PERIOD - 1);

  always_comb begin
    sat_hit = 1'b0;
    if (dir_q) phase_nxt = (phase_q == WRAP_TOP) ? '0 : phase_q + 1'b1;
    else       phase_nxt = (phase_q == '0) ? WRAP_TOP : phase_q - 1'b1;
  end
`else
  localparam logic [PHASE_W-1:0] PHASE_MAX = {1'b0, {(PHASE_W-1){1'b1}}};
  localparam logic [PHASE_W-1:0] PHASE_MIN = {1'b1, {(PHASE_W-1){1'b0}}};

  // A step past a limit leaves the count where it is and flags it.
  always_comb begin
    sat_hit   = 1'b0;
    phase_nxt = phase_q;
    if (dir_q) begin
      if (phase_q == PHASE_MAX) sat_hit = 1'b1;
      else                      phase_nxt = phase_q + 1'b1;
    end else begin
      if (phase_q == PHASE_MIN) sat_hit = 1'b1;
      else                      phase_nxt = phase_q - 1'b1;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    dir_d      = dir_q;
    locked_d   = locked_q;
    psdone_d   = 1'b0;
    phase_d    = phase_q;
    err_busy_d = err_busy_q;
    err_unl_d  = err_unl_q;
    sat_d      = sat_q;
    case (state_q)
      S_LOCKWAIT: begin
        if (psen_i) err_unl_d = 1'b1;
        if (lock_cnt_q == LOCK_TC) begin
          locked_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        // The psdone cycle still belongs to the finished step.
        if (psen_i) begin
          if (psdone_q) begin
            err_busy_d = 1'b1;
          end else begin
            dir_d     = psincdec_i;
            lat_cnt_d = LAT_LOAD;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (psen_i) err_busy_d = 1'b1;
        if (lat_cnt_q == 8'd1) begin
          psdone_d  = 1'b1;
          phase_d   = phase_nxt;
          sat_d     = sat_q | sat_hit;
          lat_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end
      default: state_d = S_LOCKWAIT;
    endcase
  end

  always_comb begin
    locked_o       = locked_q;
    psdone_o       = psdone_q;
    busy_o         = (state_q == S_BUSY);
    phase_steps_o  = phase_q;
    err_busy_o     = err_busy_q;
    err_unlocked_o = err_unl_q;
    sat_o          = sat_q;
  end

endmodule

// File: tb/tb_dps_port_responder.sv
// Bench for dps_port_responder: directed scenarios plus random traffic against a cycle-indexed model.
// Build with DPS_RESP_PHASE_WRAP_EN to exercise the wrapping phase count.
module tb_dps_port_responder;

  localparam int LAT  = 12;
  localparam int LOCK = 16;
`ifdef DPS_RESP_PHASE_WRAP_EN
  localparam int PW   = 16;
  localparam int SPP  = 448;
`else
  localparam int PW   = 4;
  localparam int PMAX = (1 << (PW-1)) - 1;
  localparam int PMIN = -(1 << (PW-1));
`endif

  logic          psclk_i = 1'b0;
  logic          rstn_i;
  logic          psen_i;
  logic          psincdec_i;
  logic          locked_o, psdone_o, busy_o;
  logic [PW-1:0] phase_steps_o;
  logic          err_busy_o, err_unlocked_o, sat_o;

  dps_port_responder #(
    .PSDONE_LATENCY(LAT),
    .LOCK_DELAY    (LOCK),
    .PHASE_W       (PW)
  ) dut (
    .psclk_i       (psclk_i),
    .rstn_i        (rstn_i),
    .psen_i        (psen_i),
    .psincdec_i    (psincdec_i),
    .locked_o      (locked_o),
    .psdone_o      (psdone_o),
    .busy_o        (busy_o),
    .phase_steps_o (phase_steps_o),
    .err_busy_o    (err_busy_o),
    .err_unlocked_o(err_unlocked_o),
    .sat_o         (sat_o)
  );

  always #5 psclk_i = ~psclk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;          // cycles since reset release, cycle 0 is the first
  int n_done;

  // Reference model: one pending step remembered by the cycle its psdone is due.
  bit m_pending;
  int m_due;
  bit m_dir;
  int m_phase;
  bit m_err_b, m_err_u, m_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_due = 0; m_dir = 0; m_phase = 0;
    m_err_b = 0; m_err_u = 0; m_sat = 0;
  endtask

  task automatic model_complete();
    int nv;
`ifdef DPS_RESP_PHASE_WRAP_EN
    m_phase = (m_phase + (m_dir ? 1 : -1) + SPP) % SPP;
`else
    nv = m_phase + (m_dir ? 1 : -1);
    if (nv > PMAX || nv < PMIN) m_sat = 1;
    else                        m_phase = nv;
`endif
  endtask

  task automatic cycle_step(input bit en, input bit dir);
    logic [PW-1:0] exp_p;
    bit            exp_done;
    psen_i     = en;
    psincdec_i = dir;
    @(negedge psclk_i);
    exp_done = m_pending && (cyc == m_due);
    if (exp_done) model_complete();
    exp_p = PW'(m_phase);
    chk("locked", 32'(locked_o), 32'(cyc >= LOCK));
    chk("psdone", 32'(psdone_o), 32'(exp_done));
    chk("busy",   32'(busy_o),   32'(m_pending && cyc < m_due));
    chk("phase",  32'(phase_steps_o), 32'(exp_p));
    chk("err_busy",     32'(err_busy_o),     32'(m_err_b));
    chk("err_unlocked", 32'(err_unlocked_o), 32'(m_err_u));
    chk("sat",    32'(sat_o), 32'(m_sat));
    if (psdone_o === 1'b1) n_done++;
    if (en) begin
      if (cyc < LOCK)     m_err_u = 1;
      else if (m_pending) m_err_b = 1;
      else begin
        m_pending = 1; m_due = cyc + LAT; m_dir = dir;
      end
    end
    if (exp_done) m_pending = 0;
    @(posedge psclk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_step(1'b0, 1'($urandom));
  endtask

  task automatic one_step(input bit dir);
    cycle_step(1'b1, dir);
    idle(LAT);
  endtask

  task automatic do_reset(input int n);
    rstn_i = 1'b0;
    psen_i = 1'b0;
    #1;
    chk("rst_locked", 32'(locked_o), 32'd0);
    chk("rst_psdone", 32'(psdone_o), 32'd0);
    chk("rst_busy",   32'(busy_o),   32'd0);
    chk("rst_phase",  32'(phase_steps_o), 32'd0);
    chk("rst_errs",   32'({err_busy_o, err_unlocked_o, sat_o}), 32'd0);
    model_reset();
    repeat (n) @(posedge psclk_i);
    #1;
    rstn_i = 1'b1;
    cyc = 0;
  endtask

  initial begin
    psen_i = 1'b0;
    psincdec_i = 1'b0;
    cyc = 0;
    do_reset(3);

    // Lock wait: request at cycle 5 is rejected, lock appears at cycle 16.
    idle(5);
    cycle_step(1'b1, 1'b1);
    idle(15);

    // Single increment with its latency window.
    n_done = 0;
    one_step(1'b1);
    idle(3);
    chk("single_done_count", 32'(n_done), 32'd1);

    // Clean controller run: 5 up, 3 down, back to back.
    do_reset(2);
    idle(LOCK + 2);
    n_done = 0;
    repeat (5) one_step(1'b1);
    repeat (3) one_step(1'b0);
    idle(2);
    chk("run_done_count", 32'(n_done), 32'd8);
    chk("run_phase", 32'(phase_steps_o), 32'(PW'(2)));
    chk("run_no_err", 32'({err_busy_o, err_unlocked_o}), 32'd0);

    // Overlapping request at T+4, and one in the psdone cycle.
    n_done = 0;
    cycle_step(1'b1, 1'b0);
    idle(3);
    cycle_step(1'b1, 1'b1);
    idle(LAT - 5);
    cycle_step(1'b1, 1'b1);
    idle(4);
    chk("overlap_done_count", 32'(n_done), 32'd1);
    chk("overlap_err", 32'(err_busy_o), 32'd1);

`ifdef DPS_RESP_PHASE_WRAP_EN
    do_reset(2);
    idle(LOCK + 1);
    one_step(1'b0);
    chk("wrap_down", 32'(phase_steps_o), 32'(SPP - 1));
    one_step(1'b1);
    chk("wrap_up", 32'(phase_steps_o), 32'd0);
`else
    do_reset(2);
    idle(LOCK + 1);
    n_done = 0;
    repeat (8) one_step(1'b1);
    chk("sat_done_count", 32'(n_done), 32'd8);
    chk("sat_hold", 32'(phase_steps_o), 32'(PW'(PMAX)));
    chk("sat_flag", 32'(sat_o), 32'd1);
    repeat (18) one_step(1'b0);
`endif

    // Reset six cycles into a step: nothing completes, lock restarts.
    cycle_step(1'b1, 1'b1);
    idle(5);
    do_reset(2);
    n_done = 0;
    idle(LOCK + LAT);
    chk("midrst_no_done", 32'(n_done), 32'd0);

    // Random traffic, including protocol violations.
    for (int i = 0; i < 600; i++)
      cycle_step(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0));
    do_reset(1);
    for (int i = 0; i < 600; i++)
      cycle_step(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
